// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Holds the pipeline via stall_o while busy and pulses done_o for one cycle
// with result_o/rd_o, which stay put until the next completion.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   ma_q, mb_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              a_sgn, b_sgn, sa, sb, div0, ovf, special, accept, last;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res;
  logic [2*XLEN-1:0] addend, prod_nxt, prod_fin;
  logic [XLEN-1:0]   mul_res, quo_nxt, div_res;
  logic [XLEN:0]     rem_sh, rem_nxt;
  logic [XLEN+1:0]   diff;
  logic              qbit;

  // Operand signedness per funct3; MUL is treated as signed since its low
  // product word is the same either way.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:                   a_sgn = 1'b1;
      default:                ;
    endcase
  end

  // Accept-time decode: magnitudes and the divide corner cases.
  always_comb begin
    sa       = a_sgn & a_i[XLEN-1];
    sb       = b_sgn & b_i[XLEN-1];
    abs_a    = sa ? -a_i : a_i;
    abs_b    = sb ? -b_i : b_i;
    div0     = (b_i == '0);
    ovf      = (op_i == 3'd4 || op_i == 3'd6) && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
    special  = op_i[2] & (div0 | ovf);
    spec_res = div0 ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
    accept   = (state_q == S_IDLE) & start_i & ~flush_i;
    last     = (cnt_q == CNT_W'(XLEN-1));
  end

  // One iteration of multiply and divide, plus final sign fix-up.
  always_comb begin
    addend   = mb_q[0] ? ({{XLEN{1'b0}}, ma_q} << cnt_q) : '0;
    prod_nxt = prod_q + addend;
    prod_fin = (sa_q ^ sb_q) ? -prod_nxt : prod_nxt;
    mul_res  = (op_q[1:0] == 2'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    rem_sh   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff     = {1'b0, rem_sh} - {2'b0, mb_q};
    qbit     = ~diff[XLEN+1];
    rem_nxt  = qbit ? diff[XLEN:0] : rem_sh;
    quo_nxt  = {quo_q[XLEN-2:0], qbit};
    if (op_q[1])
      div_res = sa_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
    else
      div_res = (sa_q ^ sb_q) ? -quo_nxt : quo_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = accept;
        if (accept) state_d = special ? S_DONE : (op_i[2] ? S_DIV : S_MUL);
      end
      S_MUL, S_DIV: begin
        stall_o = 1'b1;
        if (flush_i)   state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Working registers and the committed result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0; rd_q <= '0; sa_q <= 1'b0; sb_q <= 1'b0;
      ma_q <= '0; mb_q <= '0; prod_q <= '0; rem_q <= '0; quo_q <= '0;
      cnt_q <= '0; result_o <= '0; rd_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q   <= op_i;
          rd_q   <= rd_i;
          sa_q   <= sa;
          sb_q   <= sb;
          ma_q   <= abs_a;
          mb_q   <= abs_b;
          prod_q <= '0;
          rem_q  <= '0;
          quo_q  <= abs_a;
          cnt_q  <= '0;
          if (special) begin
            result_o <= spec_res;
            rd_o     <= rd_i;
          end
        end
        S_MUL: if (!flush_i) begin
          prod_q <= prod_nxt;
          mb_q   <= mb_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
          if (last) begin
            result_o <= mul_res;
            rd_o     <= rd_q;
          end
        end
        S_DIV: if (!flush_i) begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            result_o <= div_res;
            rd_o     <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results go into a scoreboard
// queue at issue and are popped when done_o fires.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  rd_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_res;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .rd_i(rd_i), .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble operands after accept, wait (bounded) for done_o,
  // then check latency, stall length, result, rd and the post-done hold.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    exp_t e;
    int   lat, stalls;
    bit   seen;
    e.res = exp_res;
    e.rd  = rd;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
    sb_q.push_back(e);
    #1 chk({tag, "_stall_accept"}, 32'(stall_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; rd_i = 5'($urandom);
    lat = 1; stalls = 1; seen = 1'b0;
    while (lat < 100) begin
      if (done_o) begin seen = 1'b1; break; end
      if (stall_o) stalls++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_stall_cycles"}, stalls, exp_lat);
      chk({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk({tag, "_result"}, result_o, e.res);
        chk({tag, "_rd"}, 32'(rd_o), 32'(e.rd));
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
      chk({tag, "_result_hold"}, result_o, exp_res);
      last_res = exp_res;
    end
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
    last_res = '0;
    #1;
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul_m1x7", 3'd0, 32'hFFFF_FFFF, 32'd7, 5'd3, 32'hFFFF_FFF9, 33);

    // Asynchronous reset in the middle of a multiply (count = 10).
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; a_i = 32'd9; b_i = 32'd9; rd_i = 5'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_stall", 32'(stall_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd", 32'(rd_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_o) chk("midrst_spurious_done", 32'(done_o), 32'd0);
    end

    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33);
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 33);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFF, 33);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd8, 32'd14, 33);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd9, 32'd2, 33);
    run_op("div_5_0", 3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0", 3'd7, 32'd5, 32'd0, 5'd11, 32'd5, 1);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1);

    // Flush a divide at count = 5: no completion, result untouched.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd5; a_i = 32'd1000; b_i = 32'd3; rd_i = 5'd14;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_stall", 32'(stall_o), 32'd0);
    chk("flush_done", 32'(done_o), 32'd0);
    chk("flush_result", result_o, last_res);
    repeat (40) begin
      @(negedge clk);
      if (done_o) chk("flush_spurious_done", 32'(done_o), 32'd0);
    end
    chk("flush_result_later", result_o, last_res);

    run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 5'd15, 32'd12, 33);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage. It consumes operands and rd from the ID/EX pipeline register.
- It raises stall_o while an M-extension op is in flight, so ID/EX and upstream stages hold.
- On completion it presents the result with a one-cycle done_o, which the EX/MEM register captures in place of the ALU result.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
CNT_W, 6, width of iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
start_i  input  1  ID/EX holds a valid M-extension instruction
op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a_i  input  XLEN  rs1 data (already forwarded)
b_i  input  XLEN  rs2 data (already forwarded)
rd_i  input  5  destination register
flush_i  input  1  synchronous cancel (branch/jump taken)
stall_o  output  1  hold ID/EX and upstream; combinational
done_o  output  1  result_o/rd_o valid this cycle
result_o  output  XLEN  final result
rd_o  output  5  destination of completed op

Behaviour:
- Reset (rst low, any time, mid-op included):
  - state=IDLE; done_o=0; result_o=0; rd_o=0.
  - Counter and working registers clear to 0.
- States:
  - IDLE: next is MUL, DIV or DONE.
  - MUL: XLEN iterations, then DONE.
  - DIV: XLEN iterations, then DONE.
  - DONE: one cycle, then IDLE.
- IDLE with start_i=1 and flush_i=0, on the next edge:
  - Latch op, rd and sign flags.
  - Latch operand magnitudes (two's-complement absolute value where the operand is signed for this op).
  - Go to MUL (op<4) or DIV (op>=4) with count=0.
  - Special divide cases go straight to DONE with the result computed at once:
    - b_i==0: DIV/DIVU -> all ones; REM/REMU -> a_i.
    - Signed overflow (DIV/REM, a_i=0x80000000, b_i=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
- MUL state:
  - Radix-2 shift-add into a 2*XLEN product register, one bit per cycle; count increments.
  - At count==XLEN-1, go to DONE.
  - Negate the product when sign_a XOR sign_b (signed operands only).
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- DIV state:
  - Restoring division, one quotient bit per cycle; remainder register is XLEN+1 bits.
  - After XLEN iterations, go to DONE.
  - Quotient is negated if sign_a XOR sign_b (signed). Remainder takes the sign of the dividend.
- DONE:
  - done_o=1; result_o and rd_o valid; stall_o=0, so the pipeline advances on this edge.
  - start_i is ignored in DONE (it is the same instruction).
  - Next state is IDLE.
  - result_o/rd_o hold their value until the next completion.
- stall_o = (state==IDLE & start_i & ~flush_i) | state==MUL | state==DIV.
- Latency:
  - Normal op: done_o asserts XLEN+1 cycles after the accepting edge (33 for XLEN=32).
  - Special divide case: done_o asserts 1 cycle after the accepting edge.
- flush_i=1 in MUL/DIV/DONE: next state IDLE; done_o=0 the next cycle; result_o/rd_o unchanged. flush_i in IDLE suppresses acceptance.
- Back-to-back ops: the next instruction enters ID/EX at the DONE edge. It is accepted from IDLE one cycle later (one idle cycle between ops).
- Operand changes on a_i/b_i after acceptance have no effect.

Test Plan:
- Reset pulse mid-MUL (count=10) -> state IDLE, stall_o=0, done_o=0, result_o=0 immediately, without waiting for a clock edge.
- MUL a=0xFFFFFFFF(-1), b=7 -> stall_o high 33 cycles including the accept cycle; done_o pulse with result_o=0xFFFFFFF9 and rd_o=rd_i.
- MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same -> 0. Each shows done_o exactly 1 cycle after accept, and stall_o low in the DONE cycle.
- flush_i asserted at count=5 of DIV -> IDLE next cycle, no done_o, result_o retains the prior value. A following MUL 3*4 -> 12 with normal latency.
